fp8_alu_core: RTL and testbench

FP8_ALU_CORE -- requirements
Module: fp8_alu

---
 rtl/fp8_alu_core.sv | 139 +++++++++++++
 tb/tb_fp8_alu_core.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fp8_alu_core.sv
// FP8 (1/3/4, bias 3, no subnormals) add/sub/mul/div unit.
// One registered result per cycle with overflow/underflow/zero/invalid flags.
module fp8_alu_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] result,
    output logic       overflow,
    output logic       underflow,
    output logic       zero_flag,
    output logic       invalid_op
);

    logic        a_nz, b_nz, sb_eff, div_zero;
    logic [4:0]  ma, mb, mb_div;
    logic [13:0] ia, ib;
    logic [9:0]  prod;
    logic [12:0] quot;
    logic [13:0] n;
    logic [6:0]  x;
    logic        sgn;
    logic [17:0] ext;
    logic [3:0]  p;
    logic [4:0]  top;
    logic        carry;
    logic [3:0]  fr;
    logic [6:0]  eb;
    logic [7:0]  result_d, result_q;
    logic        overflow_d, overflow_q;
    logic        underflow_d, underflow_q;
    logic        invalid_d, invalid_q;

    // Operand decode: zero codes get a zero significand so they vanish in the math.
    always_comb begin
        a_nz     = |a[6:0];
        b_nz     = |b[6:0];
        ma       = a_nz ? {1'b1, a[3:0]} : 5'd0;
        mb       = b_nz ? {1'b1, b[3:0]} : 5'd0;
        mb_div   = b_nz ? mb : 5'd1;
        ia       = {9'd0, ma} << a[6:4];
        ib       = {9'd0, mb} << b[6:4];
        prod     = {5'd0, ma} * {5'd0, mb};
        quot     = {ma, 8'd0} / {8'd0, mb_div};
        sb_eff   = b[7] ^ (op == 3'b001);
        div_zero = (op == 3'b011) && !b_nz;
    end

    // Exact magnitude n with value = n * 2^x and its sign, per operation.
    always_comb begin
        n   = '0;
        x   = '0;
        sgn = 1'b0;
        case (op)
            3'b000, 3'b001: begin
                x = -7'sd7;
                if (a[7] == sb_eff) begin
                    n   = ia + ib;
                    sgn = a[7];
                end else if (ia >= ib) begin
                    n   = ia - ib;
                    sgn = a[7];
                end else begin
                    n   = ib - ia;
                    sgn = sb_eff;
                end
            end
            3'b010: begin
                n   = {4'd0, prod};
                x   = {4'd0, a[6:4]} + {4'd0, b[6:4]} - 7'd14;
                sgn = a[7] ^ b[7];
            end
            3'b011: begin
                n   = {1'b0, quot};
                x   = {4'd0, a[6:4]} - {4'd0, b[6:4]} - 7'd8;
                sgn = a[7] ^ b[7];
            end
            default: ;
        endcase
    end

    // Normalise to 1.ffff, round half away from zero (only the round bit matters).
    always_comb begin
        ext = {n[12:0], 5'd0};
        p   = '0;
        top = '0;
        for (int i = 0; i < 14; i++) begin
            if (n[i]) begin
                p   = 4'(i);
                top = ext[i +: 5];
            end
        end
        {carry, fr} = {1'b0, top[4:1]} + {4'd0, top[0]};
        eb = {3'd0, p} + x + 7'd3 + {6'd0, carry};
    end

    // Range checks and special cases select the final code and flags.
    always_comb begin
        result_d    = 8'h00;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        invalid_d   = 1'b0;
        if (op[2] || div_zero) begin
            invalid_d = 1'b1;
        end else if (n == '0) begin
            result_d = 8'h00;
        end else if (!eb[6] && (eb[5:3] != 3'd0)) begin
            result_d   = {sgn, 7'h7F};
            overflow_d = 1'b1;
        end else if (eb[6] || (eb == 7'd0 && fr == 4'd0)) begin
            underflow_d = 1'b1;
        end else begin
            result_d = {sgn, eb[2:0], fr};
        end
    end

    // Output register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= 8'h00;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            invalid_q   <= 1'b0;
        end else begin
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            invalid_q   <= invalid_d;
        end
    end

    assign result     = result_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign invalid_op = invalid_q;
    assign zero_flag  = (result_q == 8'h00);

endmodule

// File: tb/tb_fp8_alu_core.sv
// Self-checking bench for fp8_alu_core.
// Directed cases plus random vectors against a real-arithmetic model.
module tb_fp8_alu_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] a, b;
    logic [2:0] op;
    logic [7:0] result;
    logic       overflow, underflow, zero_flag, invalid_op;
    int         n_vec;
    int         n_err;

    fp8_alu_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .op        (op),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .zero_flag (zero_flag),
        .invalid_op(invalid_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic real p2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real dec(input logic [7:0] c);
        real m;
        if (c[6:0] == 7'd0) return 0.0;
        m = (1.0 + real'(c[3:0]) / 16.0) * p2(int'(c[6:4]) - 3);
        return c[7] ? -m : m;
    endfunction

    // Returns {invalid, overflow, underflow, result}.
    function automatic logic [10:0] model(input logic [7:0] xa,
                                          input logic [7:0] xb,
                                          input logic [2:0] xop);
        real v, mag, m;
        int  k, f, e;
        logic s;
        if (xop[2]) return {3'b100, 8'h00};
        if (xop == 3'd3 && xb[6:0] == 7'd0) return {3'b100, 8'h00};
        case (xop)
            3'd0: v = dec(xa) + dec(xb);
            3'd1: v = dec(xa) - dec(xb);
            3'd2: v = dec(xa) * dec(xb);
            default: v = dec(xa) / dec(xb);
        endcase
        if (v == 0.0) return {3'b000, 8'h00};
        s   = (v < 0.0);
        mag = s ? -v : v;
        k   = 0;
        while (k < 20 && mag >= p2(k + 1)) k++;
        while (k > -20 && mag < p2(k)) k--;
        m = mag / p2(k);
        f = int'($floor((m - 1.0) * 16.0 + 0.5));
        if (f == 16) begin
            k++;
            f = 0;
        end
        e = k + 3;
        if (e > 7) return {3'b010, s, 7'h7F};
        if (e < 0 || (e == 0 && f == 0)) return {3'b001, 8'h00};
        return {3'b000, s, 3'(e), 4'(f)};
    endfunction

    task automatic apply(input logic [7:0] xa, input logic [7:0] xb,
                         input logic [2:0] xop);
        @(negedge clk);
        a  = xa;
        b  = xb;
        op = xop;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [7:0] xa,
                            input logic [7:0] xb, input logic [2:0] xop,
                            input logic [7:0] er, input logic eo,
                            input logic eu, input logic ei);
        apply(xa, xb, xop);
        chk({tag, ".res"}, result, er);
        chk({tag, ".ovf"}, {7'd0, overflow}, {7'd0, eo});
        chk({tag, ".unf"}, {7'd0, underflow}, {7'd0, eu});
        chk({tag, ".inv"}, {7'd0, invalid_op}, {7'd0, ei});
        chk({tag, ".zf"}, {7'd0, zero_flag}, {7'd0, er == 8'h00});
    endtask

    function automatic logic [7:0] pick();
        logic [7:0] sp [7];
        sp = '{8'h00, 8'h80, 8'h01, 8'h81, 8'h7F, 8'hFF, 8'h70};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 6)];
        return 8'($urandom);
    endfunction

    initial begin
        logic [10:0] exp;
        logic [7:0]  ra, rb;
        logic [2:0]  rop;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        a     = 8'h46;
        b     = 8'h34;
        op    = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.res", result, 8'h00);
        chk("rst.zf", {7'd0, zero_flag}, 8'd1);
        chk("rst.flags", {5'd0, overflow, underflow, invalid_op}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        directed("add", 8'h46, 8'h34, 3'd0, 8'h50, 0, 0, 0);
        directed("subxx", 8'h5C, 8'h5C, 3'd1, 8'h00, 0, 0, 0);
        directed("mulneg", 8'hD8, 8'h48, 3'd2, 8'hF2, 0, 0, 0);
        directed("mulovf", 8'h70, 8'h70, 3'd2, 8'h7F, 1, 0, 0);
        directed("div", 8'h64, 8'h44, 3'd3, 8'h50, 0, 0, 0);
        directed("divz", 8'h44, 8'h00, 3'd3, 8'h00, 0, 0, 1);
        directed("badop", 8'h46, 8'h34, 3'd4, 8'h00, 0, 0, 1);
        directed("badop7", 8'h7F, 8'hFF, 3'd7, 8'h00, 0, 0, 1);
        directed("mulunf", 8'h01, 8'h01, 3'd2, 8'h00, 0, 1, 0);
        directed("mul0", 8'h00, 8'hC5, 3'd2, 8'h00, 0, 0, 0);
        directed("zsub", 8'h00, 8'h46, 3'd1, 8'hC6, 0, 0, 0);
        directed("addz", 8'hB3, 8'h80, 3'd0, 8'hB3, 0, 0, 0);
        directed("zdiv", 8'h80, 8'h33, 3'd3, 8'h00, 0, 0, 0);
        directed("addovf", 8'hFF, 8'hFF, 3'd0, 8'hFF, 1, 0, 0);

        @(negedge clk);
        a     = 8'h55;
        b     = 8'h66;
        op    = 3'd2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst.res", result, 8'h00);
        chk("midrst.zf", {7'd0, zero_flag}, 8'd1);
        chk("midrst.flags", {5'd0, overflow, underflow, invalid_op}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        directed("postrst", 8'h46, 8'h34, 3'd0, 8'h50, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            ra  = pick();
            rb  = pick();
            rop = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
                                               : 3'($urandom_range(0, 3));
            exp = model(ra, rb, rop);
            apply(ra, rb, rop);
            chk("rnd.res", result, exp[7:0]);
            chk("rnd.flags", {5'd0, overflow, underflow, invalid_op},
                {5'd0, exp[9], exp[8], exp[10]});
            chk("rnd.zf", {7'd0, zero_flag}, {7'd0, exp[7:0] == 8'h00});
            if (result !== exp[7:0])
                $display("  op=%0d a=%h b=%h", rop, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
